// File: rtl/dual_xor_pkg.sv
// Shared definitions for the dual-XOR cipher configuration path: loader states and chain length.
package dual_xor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    VERIFY,
    DONE,
    ERROR
  } state_e;

  // Frame is {tx_taps, tx_state, rx_taps, rx_state}.
  localparam int unsigned FRAME_WORDS = 4;

  function automatic int unsigned chain_len(input int unsigned m);
    return FRAME_WORDS * m;
  endfunction

endpackage

// File: rtl/dual_xor_cfg_loader_if.sv
// Parallel configuration inputs, serial scan-chain link and status of the cipher config loader.
interface dual_xor_cfg_loader_if #(
  parameter int unsigned M = 32
);

  logic         start;
  logic         config_once;
  logic [M-1:0] tx_lfsr_taps;
  logic [M-1:0] tx_lfsr_state;
  logic [M-1:0] rx_lfsr_taps;
  logic [M-1:0] rx_lfsr_state;
  logic         cfg_en;
  logic         cfg_o;
  logic         cfg_i;
  logic         stream_en;
  logic         busy;
  logic         cfg_error;

  modport master (
    input  start, config_once, tx_lfsr_taps, tx_lfsr_state, rx_lfsr_taps, rx_lfsr_state, cfg_i,
    output cfg_en, cfg_o, stream_en, busy, cfg_error
  );

  modport slave (
    output start, config_once, tx_lfsr_taps, tx_lfsr_state, rx_lfsr_taps, rx_lfsr_state, cfg_i,
    input  cfg_en, cfg_o, stream_en, busy, cfg_error
  );

endinterface

// File: rtl/dual_xor_piso.sv
// N-bit parallel-load shift register, MSB out. Shifting rotates so the frame survives a full pass.
module dual_xor_piso #(
  parameter int unsigned N = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] din,
  output logic         msb
);

  logic [N-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= din;
    end else if (shift) begin
      sr_q <= {sr_q[N-2:0], sr_q[N-1]};
    end
  end

  assign msb = sr_q[N-1];

endmodule

// File: rtl/dual_xor_cfg_loader.sv
// Serialises TX/RX LFSR taps and seeds into the cipher config chain, verifies by a second pass,
// and gates the cipher stream enable on a verified load.
module dual_xor_cfg_loader
  import dual_xor_pkg::*;
#(
  parameter int unsigned M         = 32,
  parameter bit          AUTO_LOAD = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  dual_xor_cfg_loader_if.master bus
);

  localparam int unsigned    N    = chain_len(M);
  localparam int unsigned    CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            first_q;
  logic            loaded_once_q;
  logic            en_q, busy_q, stream_q;
  logic            load, shift, mismatch, last_bit, frame_msb;
  logic [N-1:0]    frame;

  assign frame = {bus.tx_lfsr_taps, bus.tx_lfsr_state, bus.rx_lfsr_taps, bus.rx_lfsr_state};

  dual_xor_piso #(
    .N(N)
  ) u_piso (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .shift(shift),
    .din  (frame),
    .msb  (frame_msb)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    load     = 1'b0;
    shift    = 1'b0;
    last_bit = (cnt_q == LAST);
    // Readback is only meaningful during the verify pass.
    mismatch = (state_q == VERIFY) && (bus.cfg_i != frame_msb);
    unique case (state_q)
      IDLE: begin
        if (bus.start || (AUTO_LOAD && first_q)) state_d = LOAD;
      end
      LOAD: begin
        load    = 1'b1;
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
        shift = 1'b1;
        if (last_bit) begin
          cnt_d   = '0;
          state_d = VERIFY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      VERIFY: begin
        shift = 1'b1;
        if (mismatch) err_d = 1'b1;
        if (last_bit) begin
          cnt_d   = '0;
          state_d = (err_q || mismatch) ? ERROR : DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.start && !(bus.config_once && loaded_once_q)) state_d = LOAD;
      end
      ERROR: begin
        if (bus.start) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      first_q       <= 1'b1;
      loaded_once_q <= 1'b0;
      en_q          <= 1'b0;
      busy_q        <= 1'b0;
      stream_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      first_q  <= 1'b0;
      en_q     <= (state_d == SHIFT) || (state_d == VERIFY);
      busy_q   <= (state_d == LOAD) || (state_d == SHIFT) || (state_d == VERIFY);
      stream_q <= (state_d == DONE);
      if (state_d == DONE) loaded_once_q <= 1'b1;
    end
  end

  assign bus.cfg_en    = en_q;
  assign bus.cfg_o     = en_q & frame_msb;
  assign bus.busy      = busy_q;
  assign bus.stream_en = stream_q;
  assign bus.cfg_error = err_q;

endmodule

// File: tb/tb_dual_xor_cfg_loader.sv
// Scoreboard bench: stimulus queues the expected serial bits, a monitor checks each cfg_en cycle.
module tb_dual_xor_cfg_loader;
  import dual_xor_pkg::*;

  localparam int unsigned M = 32;
  localparam int unsigned N = chain_len(M);
  localparam logic [N-1:0] FLIP_MASK = {{(N - 1){1'b0}}, 1'b1} << 37;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dual_xor_cfg_loader_if #(.M(M)) bus ();

  dual_xor_cfg_loader #(
    .M        (M),
    .AUTO_LOAD(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Ideal cipher scan chain; flip corrupts one stored bit on the next shift.
  logic [N-1:0] chain = '0;
  logic         flip  = 1'b0;
  always @(posedge clk) begin
    if (bus.cfg_en) chain <= {chain[N-2:0], bus.cfg_o} ^ (flip ? FLIP_MASK : '0);
  end
  assign bus.cfg_i = chain[N-1];

  bit exp_q[$];
  bit mon_exp;
  int n_pass   = 0;
  int n_checks = 0;
  int en_count = 0;
  int en_before;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cfg_en) begin
        en_count++;
        check1("shift_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check1("cfg_o_bit", bus.cfg_o, mon_exp);
        end
      end else begin
        check1("cfg_o_idle_zero", bus.cfg_o, 1'b0);
      end
    end
  end

  // Both passes send the same frame, MSB first.
  task automatic push_frame();
    logic [N-1:0] f;
    f = {bus.tx_lfsr_taps, bus.tx_lfsr_state, bus.rx_lfsr_taps, bus.rx_lfsr_state};
    for (int p = 0; p < 2; p++) begin
      for (int i = int'(N) - 1; i >= 0; i--) exp_q.push_back(f[i]);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic wait_en(input string name);
    int n = 0;
    while (!bus.cfg_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    check1(name, bus.cfg_en, 1'b1);
  endtask

  task automatic wait_not_busy(input string name);
    int n = 0;
    while (bus.busy && n < int'(2 * N) + 50) begin
      @(negedge clk);
      n++;
    end
    check1(name, bus.busy, 1'b0);
  endtask

  task automatic wait_stream(input string name);
    int n = 0;
    while (!bus.stream_en && n < int'(2 * N) + 50) begin
      @(negedge clk);
      n++;
    end
    check1(name, bus.stream_en, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.start         = 1'b0;
    bus.config_once   = 1'b0;
    bus.tx_lfsr_taps  = 32'h4800_0000;
    bus.rx_lfsr_taps  = 32'h4800_0000;
    bus.tx_lfsr_state = 32'h0000_0055;
    bus.rx_lfsr_state = 32'h0000_0055;

    // 1: reset values, then auto-load with exact latency
    push_frame();
    repeat (3) @(negedge clk);
    check1("rst_cfg_en", bus.cfg_en, 1'b0);
    check1("rst_cfg_o", bus.cfg_o, 1'b0);
    check1("rst_stream_en", bus.stream_en, 1'b0);
    check1("rst_busy", bus.busy, 1'b0);
    check1("rst_cfg_error", bus.cfg_error, 1'b0);
    rst       = 1'b0;
    en_before = en_count;
    repeat (257) @(posedge clk);
    #1 check1("stream_en_before_258", bus.stream_en, 1'b0);
    @(posedge clk);
    #1 check1("stream_en_at_258", bus.stream_en, 1'b1);
    checkn("auto_cfg_en_cycles", en_count - en_before, int'(2 * N));
    check1("auto_cfg_error", bus.cfg_error, 1'b0);
    checkn("auto_queue_empty", exp_q.size(), 0);

    // 2: corrupted chain -> ERROR, then clean retry
    push_frame();
    pulse_start();
    wait_en("corrupt_en_rise");
    repeat (N) @(negedge clk);
    flip = 1'b1;
    @(negedge clk) flip = 1'b0;
    check1("corrupt_no_early_error", bus.cfg_error, 1'b0);
    wait_not_busy("corrupt_finish");
    @(negedge clk);
    check1("corrupt_cfg_error", bus.cfg_error, 1'b1);
    check1("corrupt_stream_en", bus.stream_en, 1'b0);
    repeat (10) @(negedge clk);
    check1("error_held", bus.cfg_error, 1'b1);
    check1("error_stream_low", bus.stream_en, 1'b0);
    push_frame();
    pulse_start();
    @(negedge clk);
    check1("retry_error_cleared", bus.cfg_error, 1'b0);
    wait_not_busy("retry_finish");
    @(negedge clk);
    check1("retry_stream_en", bus.stream_en, 1'b1);
    check1("retry_cfg_error", bus.cfg_error, 1'b0);

    // 3: config_once blocks a reload from DONE; clearing it allows one
    bus.config_once = 1'b1;
    pulse_start();
    repeat (20) @(negedge clk);
    check1("once_stream_held", bus.stream_en, 1'b1);
    check1("once_not_busy", bus.busy, 1'b0);
    bus.config_once = 1'b0;
    push_frame();
    pulse_start();
    check1("reload_busy", bus.busy, 1'b1);
    check1("reload_stream_low", bus.stream_en, 1'b0);
    wait_not_busy("reload_finish");
    @(negedge clk);
    check1("reload_stream_en", bus.stream_en, 1'b1);

    // 4: reset at cnt=50 mid-shift, then auto-load from scratch
    push_frame();
    pulse_start();
    wait_en("midrst_en_rise");
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check1("midrst_cfg_en", bus.cfg_en, 1'b0);
    check1("midrst_busy", bus.busy, 1'b0);
    check1("midrst_stream_en", bus.stream_en, 1'b0);
    exp_q.delete();
    push_frame();
    rst = 1'b0;
    @(negedge clk);
    check1("midrst_stream_still_low", bus.stream_en, 1'b0);
    wait_stream("midrst_reload");
    check1("midrst_cfg_error", bus.cfg_error, 1'b0);
    checkn("midrst_queue_empty", exp_q.size(), 0);

    // 5: seeds change during shift; snapshot must be sent
    push_frame();
    pulse_start();
    wait_en("snap_en_rise");
    bus.tx_lfsr_state = 32'hAAAA_AAAA;
    bus.rx_lfsr_state = 32'hAAAA_AAAA;
    wait_not_busy("snap_finish");
    @(negedge clk);
    check1("snap_stream_en", bus.stream_en, 1'b1);
    check1("snap_cfg_error", bus.cfg_error, 1'b0);
    checkn("snap_queue_empty", exp_q.size(), 0);

    // 6: start held through a whole load -> exactly one load
    push_frame();
    en_before = en_count;
    @(negedge clk) bus.start = 1'b1;
    wait_en("hold_en_rise");
    repeat (2 * N - 1) @(negedge clk);
    bus.start = 1'b0;
    wait_not_busy("hold_finish");
    repeat (10) @(negedge clk);
    check1("hold_stream_en", bus.stream_en, 1'b1);
    check1("hold_not_busy", bus.busy, 1'b0);
    checkn("hold_cfg_en_cycles", en_count - en_before, int'(2 * N));
    checkn("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
